vxe_cu_cmd_issue: RTL
=====================

// Module: vxe_cu_cmd_issue
//
// PURPOSE
// Command-stream side of the CU execute-unit control interface. Takes fetched 64-bit command
// words, decodes NOP/SYNC locally and reports them to vxe_cu_exec_unit as one-cycle pulses
// (cmd_nop/cmd_sync/cmd_sync_stop/cmd_sync_intr). Forwards all other valid commands to dispatch
// through a small FIFO. Obeys the exec unit's halt/unhalt/stop_drain controls and raises decode faults.
//
// PARAMETERS
// CMD_WIDTH   64  command word width; opcode is bits [CMD_WIDTH-1 -: 5]
// FIFO_DEPTH  4   forward-FIFO entries (power of two, >=2)
//
// PORTS
// clk              in   1          clock
// rst              in   1          synchronous reset, active-high
// i_cmd_data       in   CMD_WIDTH  command word from fetch queue
// i_cmd_vld        in   1          i_cmd_data valid
// o_cmd_rd         out  1          command consumed this cycle (combinational)
// o_cmd_nop        out  1          pulse: NOP consumed
// o_cmd_sync       out  1          pulse: SYNC issued
// o_cmd_sync_stop  out  1          with o_cmd_sync: SYNC stop flag (bit 58)
// o_cmd_sync_intr  out  1          with o_cmd_sync: SYNC interrupt flag (bit 57)
// i_halt           in   1          pulse from exec unit: stop consuming
// i_unhalt         in   1          pulse from exec unit: start/resume
// i_stop_drain     in   1          level from exec unit: flush and discard
// o_dis_data       out  CMD_WIDTH  command to dispatch
// o_dis_vld        out  1          o_dis_data valid (FIFO non-empty)
// i_dis_rdy        in   1          dispatch accepts head
// o_active         out  1          FIFO non-empty (feeds dis_pipes_active)
// o_flt_decode     out  1          pulse: illegal opcode consumed
//
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty; all outputs 0 (o_cmd_rd is combinational and 0 in IDLE).
// - Opcodes: 0x00 NOP, 0x01 SYNC, 0x08-0x17 forwardable; anything else illegal.
// - States: IDLE, RUN, SYNC, HALT, DRAIN.
//     IDLE -> RUN on i_unhalt.
//     RUN: if i_cmd_vld && !i_halt && !i_stop_drain, consume the head:
//          NOP: o_cmd_rd=1 -> o_cmd_nop pulse next cycle.
//          fwd: o_cmd_rd=1 only when count<FIFO_DEPTH (no same-cycle pass-through when full).
//          SYNC: o_cmd_rd=0 -> SYNC.
//          illegal: o_cmd_rd=1 -> o_flt_decode pulse next cycle, then HALT.
//     SYNC: wait for FIFO empty; then o_cmd_rd=1 -> o_cmd_sync/_stop/_intr pulse next cycle, then HALT.
//     HALT: no consumption. i_unhalt -> RUN.
//     DRAIN: o_cmd_rd=i_cmd_vld; words discarded with no pulses; FIFO cleared.
//          Deassertion of i_stop_drain -> IDLE.
// - Priority, any state: rst > i_stop_drain (-> DRAIN) > i_halt (-> HALT) > i_unhalt.
// - i_halt in SYNC -> HALT without issuing the SYNC; the SYNC word stays at the input.
// - Latency: forward word consumed at edge N -> o_dis_vld at N+1 if FIFO was empty.
//     Dispatch pop occurs on o_dis_vld && i_dis_rdy. Push and pop in the same cycle keep count.
// - FIFO pop continues in HALT/SYNC/IDLE; it is suppressed only in DRAIN (flush).
// - Pulses are registered and exactly one cycle. o_cmd_sync_stop/_intr are 0 whenever o_cmd_sync=0.
// - Mid-operation rst: FIFO and state cleared in the same edge; no pulse follows.
//
// STRUCTURE
// - Shared include vxe_cu_cmd.vh: opcode localparams, opcode field position, SYNC flag bit positions.
// - Sub-module vxe_cu_cmd_fifo: synchronous FIFO with count output, parameterised by width and depth.
// - The top level contains the FSM, decode, and pulse registers.
//
// TESTING
// - reset, i_unhalt, 3 fwd (op 0x08) words with i_dis_rdy=1 -> o_dis_vld from +1 cycle, words in order,
//   o_active falls 1 cycle after the last pop.
// - NOP then SYNC with stop=1, intr=1, i_dis_rdy=0 for 4 cycles -> o_cmd_nop pulse; SYNC held until FIFO
//   empties; then o_cmd_sync=o_cmd_sync_stop=o_cmd_sync_intr=1 for one cycle; no consumption until i_unhalt.
// - 6 fwd words, i_dis_rdy=0 -> exactly 4 consumed, o_cmd_rd=0 with count=4; one pop -> one more consumed.
// - opcode 0x1F -> o_flt_decode for one cycle, HALT; i_stop_drain for 5 cycles -> FIFO flushed,
//   input words discarded, IDLE after deassert.
// - i_halt and i_unhalt in the same cycle during RUN -> HALT; i_stop_drain in SYNC -> DRAIN, no o_cmd_sync.
// - rst asserted with FIFO=2 and a SYNC pending -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/vxe_cu_cmd_issue_pkg.sv
// Package: vxe_cu_cmd_issue_pkg
// Purpose: shared opcode encodings, SYNC flag positions, FSM state type and
//          the opcode classifier used by the CU command-issue block.
// Contents:
//   OPC_*           opcode values (5-bit field at the top of the command word)
//   SYNC_*_OFS      SYNC flag positions, counted down from the word MSB
//   cu_state_e      command-issue FSM states
//   cmd_kind_e      decoded command class
//   decode_opc()    opcode -> command class
package vxe_cu_cmd_issue_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_NOP    = 5'h00;
  localparam logic [OPC_W-1:0] OPC_SYNC   = 5'h01;
  localparam logic [OPC_W-1:0] OPC_FWD_LO = 5'h08;
  localparam logic [OPC_W-1:0] OPC_FWD_HI = 5'h17;

  // Flag bit = CMD_WIDTH - offset (bits 58 and 57 of a 64-bit word).
  localparam int SYNC_STOP_OFS = 6;
  localparam int SYNC_INTR_OFS = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SYNC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_DRAIN = 3'd4
  } cu_state_e;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_SYNC = 2'd1,
    CMD_FWD  = 2'd2,
    CMD_ILL  = 2'd3
  } cmd_kind_e;

  function automatic cmd_kind_e decode_opc(input logic [OPC_W-1:0] opc);
    cmd_kind_e kind;
    if (opc == OPC_NOP) begin
      kind = CMD_NOP;
    end else if (opc == OPC_SYNC) begin
      kind = CMD_SYNC;
    end else if ((opc >= OPC_FWD_LO) && (opc <= OPC_FWD_HI)) begin
      kind = CMD_FWD;
    end else begin
      kind = CMD_ILL;
    end
    return kind;
  endfunction

endpackage

// File: rtl/vxe_cu_cmd_fifo.sv
// Module: vxe_cu_cmd_fifo
// Purpose: small synchronous FIFO with occupancy count. Flush has priority over
//          push/pop. Head data reads as zero while empty.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_flush         drop all entries
//   i_push, i_data  write one entry (ignored when full)
//   i_pop           drop head entry (ignored when empty)
//   o_head          head entry
//   o_count         number of stored entries (0..DEPTH)
module vxe_cu_cmd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/vxe_cu_cmd_issue.sv
// Module: vxe_cu_cmd_issue
// Purpose: command-stream side of the CU execute-unit control interface.
//          Decodes NOP/SYNC locally into one-cycle pulses, forwards other legal
//          commands to dispatch through a FIFO, follows halt/unhalt/stop_drain
//          from the exec unit and flags illegal opcodes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_cmd_data/i_cmd_vld     command word from fetch; o_cmd_rd consumes it (comb.)
//   o_cmd_nop                pulse: NOP consumed
//   o_cmd_sync(_stop/_intr)  pulse: SYNC issued, with its flags
//   i_halt/i_unhalt          exec-unit pulses; i_stop_drain is a level
//   o_dis_data/o_dis_vld     FIFO head to dispatch; i_dis_rdy pops it
//   o_active                 FIFO non-empty
//   o_flt_decode             pulse: illegal opcode consumed
module vxe_cu_cmd_issue
  import vxe_cu_cmd_issue_pkg::*;
#(
  parameter int CMD_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_WIDTH-1:0] i_cmd_data,
  input  logic                 i_cmd_vld,
  output logic                 o_cmd_rd,
  output logic                 o_cmd_nop,
  output logic                 o_cmd_sync,
  output logic                 o_cmd_sync_stop,
  output logic                 o_cmd_sync_intr,
  input  logic                 i_halt,
  input  logic                 i_unhalt,
  input  logic                 i_stop_drain,
  output logic [CMD_WIDTH-1:0] o_dis_data,
  output logic                 o_dis_vld,
  input  logic                 i_dis_rdy,
  output logic                 o_active,
  output logic                 o_flt_decode
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cu_state_e        r_state;
  logic             r_cmd_nop;
  logic             r_cmd_sync;
  logic             r_cmd_sync_stop;
  logic             r_cmd_sync_intr;
  logic             r_flt_decode;

  cmd_kind_e        w_kind;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_go;
  logic             w_rd;
  logic             w_push;
  logic             w_pop;
  logic             w_take_nop;
  logic             w_take_ill;
  logic             w_take_sync;

  assign w_kind  = decode_opc(i_cmd_data[CMD_WIDTH-1 -: OPC_W]);
  assign w_full  = (w_count == CW'(FIFO_DEPTH));
  assign w_empty = (w_count == '0);
  // halt/stop_drain in the same cycle block consumption outright.
  assign w_go    = i_cmd_vld && !i_halt && !i_stop_drain;

  // Consumption decode: which word class is taken this cycle.
  always_comb begin
    w_rd        = 1'b0;
    w_push      = 1'b0;
    w_take_nop  = 1'b0;
    w_take_ill  = 1'b0;
    w_take_sync = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_go) begin
          case (w_kind)
            CMD_NOP: begin
              w_rd       = 1'b1;
              w_take_nop = 1'b1;
            end
            CMD_FWD: begin
              // No pass-through when full: a pop this cycle does not make room.
              w_rd   = !w_full;
              w_push = !w_full;
            end
            CMD_ILL: begin
              w_rd       = 1'b1;
              w_take_ill = 1'b1;
            end
            default: begin
              w_rd = 1'b0;
            end
          endcase
        end else begin
          w_rd = 1'b0;
        end
      end
      ST_SYNC: begin
        // SYNC word has been parked at the input; issue once dispatch is idle.
        w_take_sync = w_go && w_empty;
        w_rd        = w_go && w_empty;
      end
      ST_DRAIN: begin
        w_rd = i_cmd_vld;
      end
      default: begin
        w_rd = 1'b0;
      end
    endcase
  end

  assign w_pop = o_dis_vld && i_dis_rdy && (r_state != ST_DRAIN);

  // Control FSM plus registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cmd_nop       <= 1'b0;
      r_cmd_sync      <= 1'b0;
      r_cmd_sync_stop <= 1'b0;
      r_cmd_sync_intr <= 1'b0;
      r_flt_decode    <= 1'b0;
    end else begin
      r_cmd_nop       <= w_take_nop;
      r_flt_decode    <= w_take_ill;
      r_cmd_sync      <= w_take_sync;
      r_cmd_sync_stop <= w_take_sync && i_cmd_data[CMD_WIDTH-SYNC_STOP_OFS];
      r_cmd_sync_intr <= w_take_sync && i_cmd_data[CMD_WIDTH-SYNC_INTR_OFS];
      if (i_stop_drain) begin
        r_state <= ST_DRAIN;
      end else if (r_state == ST_DRAIN) begin
        r_state <= ST_IDLE;
      end else if (i_halt) begin
        r_state <= ST_HALT;
      end else begin
        case (r_state)
          ST_IDLE: if (i_unhalt) r_state <= ST_RUN;
          ST_RUN: begin
            if (i_cmd_vld && (w_kind == CMD_SYNC)) r_state <= ST_SYNC;
            else if (w_take_ill)                   r_state <= ST_HALT;
            else                                   r_state <= ST_RUN;
          end
          ST_SYNC: if (w_take_sync) r_state <= ST_HALT;
          ST_HALT: if (i_unhalt)    r_state <= ST_RUN;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  vxe_cu_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (r_state == ST_DRAIN),
    .i_push  (w_push),
    .i_data  (i_cmd_data),
    .i_pop   (w_pop),
    .o_head  (o_dis_data),
    .o_count (w_count)
  );

  assign o_cmd_rd        = w_rd;
  assign o_cmd_nop       = r_cmd_nop;
  assign o_cmd_sync      = r_cmd_sync;
  assign o_cmd_sync_stop = r_cmd_sync_stop;
  assign o_cmd_sync_intr = r_cmd_sync_intr;
  assign o_flt_decode    = r_flt_decode;
  assign o_dis_vld       = !w_empty;
  assign o_active        = !w_empty;

endmodule
